// File: rtl/hex_scroller.sv
// Scrolling six-digit seven-segment stage: a 4-deep character FIFO feeds
// a digit shift chain, one character per scroll tick, right-to-left.
module hex_scroller #(
   parameter int unsigned TICK_DIV = 4
) (
   input  logic       Clock,
   input  logic       Resetn,
   input  logic       clear,
   input  logic [7:0] char_in,
   input  logic       char_valid,
   output logic       char_ready,
   output logic [6:0] HEX0,
   output logic [6:0] HEX1,
   output logic [6:0] HEX2,
   output logic [6:0] HEX3,
   output logic [6:0] HEX4,
   output logic [6:0] HEX5,
   output logic [2:0] level
);

   localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
   localparam logic [6:0]  BLANK     = 7'b1111111;

   logic [7:0]  fifo_mem [4];
   logic [1:0]  rd_ptr;
   logic [1:0]  wr_ptr;
   logic [2:0]  count;
   logic [15:0] tick_cnt;
   logic [6:0]  digit [6];
   logic        tick;
   logic        full;
   logic        empty;
   logic        push;
   logic        pop;

   function automatic logic [6:0] decode_char(input logic [7:0] c);
      logic [6:0] seg;
      case (c)
         8'd65:   seg = 7'b0001000;
         8'd98:   seg = 7'b0000011;
         8'd67:   seg = 7'b1000110;
         8'd100:  seg = 7'b0100001;
         8'd69:   seg = 7'b0000110;
         8'd70:   seg = 7'b0001110;
         8'd103:  seg = 7'b0010000;
         8'd104:  seg = 7'b0001011;
         8'd48:   seg = 7'b1000000;
         8'd49:   seg = 7'b1111001;
         8'd50:   seg = 7'b0100100;
         8'd51:   seg = 7'b0110000;
         8'd52:   seg = 7'b0011001;
         8'd53:   seg = 7'b0010010;
         8'd54:   seg = 7'b0000010;
         8'd55:   seg = 7'b1111000;
         8'd56:   seg = 7'b0000000;
         8'd57:   seg = 7'b0010000;
         default: seg = BLANK;
      endcase
      return seg;
   endfunction

   // clear blocks acceptance so a character offered during clear is not dropped
   assign full       = (count == 3'd4);
   assign empty      = (count == 3'd0);
   assign char_ready = !full && !clear;
   assign tick       = (tick_cnt == TICK_LAST);
   assign push       = char_valid && char_ready;
   assign pop        = tick && !empty && !clear;

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         tick_cnt <= 16'd0;
      end else if (clear || tick) begin
         tick_cnt <= 16'd0;
      end else begin
         tick_cnt <= tick_cnt + 16'd1;
      end
   end

   always_ff @(posedge Clock) begin
      if (push) begin
         fifo_mem[wr_ptr] <= char_in;
      end
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         rd_ptr <= 2'd0;
         wr_ptr <= 2'd0;
         count  <= 3'd0;
      end else if (clear) begin
         rd_ptr <= 2'd0;
         wr_ptr <= 2'd0;
         count  <= 3'd0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 2'd1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 2'd1;
         end
         if (push && !pop) begin
            count <= count + 3'd1;
         end else if (pop && !push) begin
            count <= count - 3'd1;
         end
      end
   end

   // digit[0] is the rightmost position; new characters enter there
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         for (int i = 0; i < 6; i++) begin
            digit[i] <= BLANK;
         end
      end else if (clear) begin
         for (int i = 0; i < 6; i++) begin
            digit[i] <= BLANK;
         end
      end else if (pop) begin
         for (int i = 5; i > 0; i--) begin
            digit[i] <= digit[i-1];
         end
         digit[0] <= decode_char(fifo_mem[rd_ptr]);
      end
   end

   assign HEX0  = digit[0];
   assign HEX1  = digit[1];
   assign HEX2  = digit[2];
   assign HEX3  = digit[3];
   assign HEX4  = digit[4];
   assign HEX5  = digit[5];
   assign level = count;

endmodule

// File: tb/tb_hex_scroller.sv
// Directed bench for hex_scroller: three instances at TICK_DIV 4, 100 and 1
// share clock and reset; decode is table-driven, corner cases are sequences.
module tb_hex_scroller;

   typedef struct {
      logic [7:0] ch;
      logic [6:0] hex;
   } vec_t;

   logic       Clock;
   logic       Resetn;

   logic       clr4, v4, rdy4;
   logic [7:0] c4;
   logic [6:0] hx4 [6];
   logic [2:0] lvl4;

   logic       clr100, v100, rdy100;
   logic [7:0] c100;
   logic [6:0] hx100 [6];
   logic [2:0] lvl100;

   logic       clr1, v1, rdy1;
   logic [7:0] c1;
   logic [6:0] hx1 [6];
   logic [2:0] lvl1;

   int assertCount;
   int failCount;
   int idx;
   int cyc;
   logic acc;
   logic sawFull;
   vec_t vecs [22];
   logic [7:0] msg [8];

   hex_scroller #(.TICK_DIV(4)) u4 (
      .Clock(Clock), .Resetn(Resetn), .clear(clr4), .char_in(c4),
      .char_valid(v4), .char_ready(rdy4),
      .HEX0(hx4[0]), .HEX1(hx4[1]), .HEX2(hx4[2]), .HEX3(hx4[3]),
      .HEX4(hx4[4]), .HEX5(hx4[5]), .level(lvl4)
   );

   hex_scroller #(.TICK_DIV(100)) u100 (
      .Clock(Clock), .Resetn(Resetn), .clear(clr100), .char_in(c100),
      .char_valid(v100), .char_ready(rdy100),
      .HEX0(hx100[0]), .HEX1(hx100[1]), .HEX2(hx100[2]), .HEX3(hx100[3]),
      .HEX4(hx100[4]), .HEX5(hx100[5]), .level(lvl100)
   );

   hex_scroller #(.TICK_DIV(1)) u1 (
      .Clock(Clock), .Resetn(Resetn), .clear(clr1), .char_in(c1),
      .char_valid(v1), .char_ready(rdy1),
      .HEX0(hx1[0]), .HEX1(hx1[1]), .HEX2(hx1[2]), .HEX3(hx1[3]),
      .HEX4(hx1[4]), .HEX5(hx1[5]), .level(lvl1)
   );

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // push one character into the TICK_DIV=1 instance and let it be displayed
   task automatic applyStimulus(input logic [7:0] ch);
      c1 = ch;
      v1 = 1'b1;
      @(posedge Clock);
      #1 v1 = 1'b0;
      @(posedge Clock);
      #1;
   endtask

   task automatic edges(input int n);
      repeat (n) @(posedge Clock);
      #1;
   endtask

   initial begin
      assertCount = 0;
      failCount   = 0;
      vecs = '{
         '{8'd65,  7'b0001000}, '{8'd98,  7'b0000011}, '{8'd67,  7'b1000110},
         '{8'd100, 7'b0100001}, '{8'd69,  7'b0000110}, '{8'd70,  7'b0001110},
         '{8'd103, 7'b0010000}, '{8'd104, 7'b0001011}, '{8'd49,  7'b1111001},
         '{8'd50,  7'b0100100}, '{8'd51,  7'b0110000}, '{8'd52,  7'b0011001},
         '{8'd53,  7'b0010010}, '{8'd54,  7'b0000010}, '{8'd56,  7'b0000000},
         '{8'd57,  7'b0010000}, '{8'd32,  7'b1111111}, '{8'd99,  7'b1111111},
         '{8'd55,  7'b1111000}, '{8'h3F,  7'b1111111}, '{8'd97,  7'b1111111},
         '{8'd48,  7'b1000000}
      };
      msg = '{8'd65, 8'd98, 8'd67, 8'd100, 8'd69, 8'd70, 8'd103, 8'd104};

      Resetn = 1'b1;
      clr4 = 0; v4 = 0; c4 = 0;
      clr100 = 0; v100 = 0; c100 = 0;
      clr1 = 0; v1 = 0; c1 = 0;

      // reset asserted between edges must blank everything at once
      #2 Resetn = 1'b0;
      #1;
      checkOutput("reset_hex", {hx4[5], hx4[4], hx4[3], hx4[2], hx4[1], hx4[0]}, {42{1'b1}});
      checkOutput("reset_level", lvl4, 3'd0);
      checkOutput("reset_ready", rdy4, 1'b1);
      @(posedge Clock);
      @(posedge Clock);
      #2 Resetn = 1'b1;

      // single character at TICK_DIV=4: shows on the 4th edge
      c4 = 8'd65;
      v4 = 1'b1;
      edges(1);
      v4 = 1'b0;
      checkOutput("single_level_after_push", lvl4, 3'd1);
      checkOutput("single_hex0_early", hx4[0], 7'b1111111);
      edges(2);
      checkOutput("single_hex0_edge3", hx4[0], 7'b1111111);
      checkOutput("single_level_edge3", lvl4, 3'd1);
      edges(1);
      checkOutput("single_hex0_edge4", hx4[0], 7'b0001000);
      checkOutput("single_hex_upper", {hx4[5], hx4[4], hx4[3], hx4[2], hx4[1]}, {35{1'b1}});
      checkOutput("single_level_edge4", lvl4, 3'd0);

      // streaming with back-pressure
      idx = 0;
      cyc = 0;
      sawFull = 1'b0;
      while (idx < 8 && cyc < 200) begin
         c4 = msg[idx];
         v4 = 1'b1;
         @(negedge Clock);
         acc = rdy4;
         if (lvl4 == 3'd4) sawFull = 1'b1;
         checkOutput("stream_ready_vs_level", rdy4, (lvl4 != 3'd4));
         @(posedge Clock);
         #1;
         if (acc) idx++;
         cyc++;
      end
      v4 = 1'b0;
      checkOutput("stream_all_accepted", idx, 8);
      checkOutput("stream_saw_full", sawFull, 1'b1);
      cyc = 0;
      while (lvl4 != 3'd0 && cyc < 100) begin
         edges(1);
         cyc++;
      end
      checkOutput("stream_drained", lvl4, 3'd0);
      checkOutput("stream_hex", {hx4[5], hx4[4], hx4[3], hx4[2], hx4[1], hx4[0]},
                  {7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110, 7'b0010000, 7'b0001011});

      // decode table on the TICK_DIV=1 instance
      for (int i = 0; i < 22; i++) begin
         applyStimulus(vecs[i].ch);
         checkOutput($sformatf("decode_%0d", vecs[i].ch), hx1[0], vecs[i].hex);
         checkOutput($sformatf("decode_level_%0d", i), lvl1, 3'd0);
      end
      checkOutput("decode_corner_hex3_0", {hx1[3], hx1[2], hx1[1], hx1[0]},
                  {7'b1111000, 7'b1111111, 7'b1111111, 7'b1000000});

      // full FIFO at TICK_DIV=100, aligned by a clear pulse
      clr100 = 1'b1;
      edges(1);
      clr100 = 1'b0;
      v100 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         c100 = 8'd49 + 8'(k);
         edges(1);
      end
      c100 = 8'd53;
      checkOutput("full_level4", lvl100, 3'd4);
      checkOutput("full_ready_low", rdy100, 1'b0);
      edges(95);
      checkOutput("full_held_level", lvl100, 3'd4);
      edges(1);
      checkOutput("full_tick_level3", lvl100, 3'd3);
      checkOutput("full_tick_ready", rdy100, 1'b1);
      checkOutput("full_tick_hex0", hx100[0], 7'b1111001);
      edges(1);
      v100 = 1'b0;
      checkOutput("full_fifth_accepted", lvl100, 3'd4);

      // clear with level=3, valid high and a tick due
      clr4 = 1'b1;
      edges(1);
      clr4 = 1'b0;
      v4 = 1'b1;
      c4 = 8'd49;
      edges(1);
      c4 = 8'd50;
      edges(1);
      c4 = 8'd51;
      edges(1);
      c4 = 8'd52;
      checkOutput("clr_level_before", lvl4, 3'd3);
      clr4 = 1'b1;
      #1;
      checkOutput("clr_ready_forced_low", rdy4, 1'b0);
      edges(1);
      clr4 = 1'b0;
      v4 = 1'b0;
      checkOutput("clr_hex_blank", {hx4[5], hx4[4], hx4[3], hx4[2], hx4[1], hx4[0]}, {42{1'b1}});
      checkOutput("clr_level0", lvl4, 3'd0);
      c4 = 8'd69;
      v4 = 1'b1;
      edges(1);
      v4 = 1'b0;
      checkOutput("clr_push_level", lvl4, 3'd1);
      edges(2);
      checkOutput("clr_hex0_early", hx4[0], 7'b1111111);
      edges(1);
      checkOutput("clr_hex0_tick", hx4[0], 7'b0000110);

      // clear at a non-tick phase must restart the counter
      edges(1);
      clr4 = 1'b1;
      edges(1);
      clr4 = 1'b0;
      c4 = 8'd70;
      v4 = 1'b1;
      edges(1);
      v4 = 1'b0;
      edges(2);
      checkOutput("restart_hex0_early", hx4[0], 7'b1111111);
      edges(1);
      checkOutput("restart_hex0_tick", hx4[0], 7'b0001110);

      // reset mid-scroll blanks without a clock
      c4 = 8'd65;
      v4 = 1'b1;
      edges(1);
      v4 = 1'b0;
      #2 Resetn = 1'b0;
      #1;
      checkOutput("midreset_hex0", hx4[0], 7'b1111111);
      checkOutput("midreset_level", lvl4, 3'd0);
      checkOutput("midreset_ready", rdy4, 1'b1);
      edges(1);
      Resetn = 1'b1;
      edges(2);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
